// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer on a four-phase strobe/acknowledge bus.
// Four 32-bit registers (CTRL, LOAD, COUNT, STATUS) with byte-lane writes, a prescaler and a level interrupt.
module bus_timer #(
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        irq_o
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  state_t                  state_q, state_d;
  logic                    en_q, en_d;
  logic                    auto_q, auto_d;
  logic                    ie_q, ie_d;
  logic [PRESCALE_W-1:0]   pre_q, pre_d;
  logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
  logic [31:0]             load_q, load_d;
  logic [31:0]             count_q, count_d;
  logic                    exp_q, exp_d;
  logic [31:0]             dat_d;
  logic                    irq_d;

  logic        access, wr_ctrl, wr_load, wr_count, wr_status;
  logic        tick, tick_eff, expire;
  logic [31:0] ctrl_rd, ctrl_new, rd_mux;
  logic        unused;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++)
      if (sel[k]) res[8*k +: 8] = wdata[8*k +: 8];
    return res;
  endfunction

  assign unused = ^{adr_i[31:4], adr_i[1:0], ctrl_new};
  assign ack_o  = (state_q == ACK);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d  = state_q;
    en_d     = en_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    pre_d    = pre_q;
    pcnt_d   = pcnt_q;
    load_d   = load_q;
    count_d  = count_q;
    exp_d    = exp_q;
    dat_d    = dat_o;
    irq_d    = exp_q & ie_q;

    ctrl_rd  = '0;
    ctrl_rd[0] = en_q;
    ctrl_rd[1] = auto_q;
    ctrl_rd[2] = ie_q;
    ctrl_rd[16 +: PRESCALE_W] = pre_q;

    case (adr_i[3:2])
      REG_CTRL:  rd_mux = ctrl_rd;
      REG_LOAD:  rd_mux = load_q;
      REG_COUNT: rd_mux = count_q;
      default:   rd_mux = {31'd0, exp_q};
    endcase

    access    = (state_q == IDLE) && stb_i;
    wr_ctrl   = access && we_i && (adr_i[3:2] == REG_CTRL);
    wr_load   = access && we_i && (adr_i[3:2] == REG_LOAD);
    wr_count  = access && we_i && (adr_i[3:2] == REG_COUNT);
    wr_status = access && we_i && (adr_i[3:2] == REG_STATUS);
    ctrl_new  = merge_lanes(ctrl_rd, dat_i, sel_i);

    case (state_q)
      IDLE:    if (stb_i)  state_d = ACK;
      default: if (!stb_i) state_d = IDLE;
    endcase

    if (access && !we_i) dat_d = rd_mux;

    // A COUNT write, or a CTRL write that disables the timer, swallows a coincident tick.
    tick     = en_q && (pcnt_q == pre_q);
    tick_eff = tick && !wr_count && !(wr_ctrl && !ctrl_new[0]);
    expire   = tick_eff && (count_q == 32'd0);

    if (!en_q || wr_ctrl || tick) pcnt_d = '0;
    else                          pcnt_d = pcnt_q + PRESCALE_W'(1);

    if (wr_count) begin
      count_d = merge_lanes(count_q, dat_i, sel_i);
    end else if (tick_eff) begin
      if (count_q != 32'd0) count_d = count_q - 32'd1;
      else if (auto_q)      count_d = load_q;
    end

    if (expire && !auto_q) en_d = 1'b0;
    if (wr_ctrl) begin
      en_d   = ctrl_new[0];
      auto_d = ctrl_new[1];
      ie_d   = ctrl_new[2];
      pre_d  = ctrl_new[16 +: PRESCALE_W];
    end

    if (wr_load) load_d = merge_lanes(load_q, dat_i, sel_i);

    if (wr_status && sel_i[0] && dat_i[0]) exp_d = 1'b0;
    if (expire)                            exp_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      pre_q   <= '0;
      pcnt_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
      dat_o   <= '0;
      irq_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      dat_o   <= dat_d;
      irq_o   <= irq_d;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: read data is scoreboarded, timing is measured in clock edges.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stb_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel_i = '0;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        irq_o;

  localparam logic [31:0] A_CTRL   = 32'h0000_0000;
  localparam logic [31:0] A_LOAD   = 32'h0000_0004;
  localparam logic [31:0] A_COUNT  = 32'h0000_0008;
  localparam logic [31:0] A_STATUS = 32'h0000_000C;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] sb_q[$];

  bus_timer #(.PRESCALE_W(16)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .stb_i (stb_i),
    .we_i  (we_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .sel_i (sel_i),
    .ack_o (ack_o),
    .dat_o (dat_o),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks start and end at a falling edge; the access commits on the next rising edge.
  task automatic bus_write(input logic [31:0] adr, input logic [31:0] data,
                           input logic [3:0] sel, output int commit);
    int n;
    stb_i = 1'b1; we_i = 1'b1; adr_i = adr; dat_i = data; sel_i = sel;
    @(negedge clk);
    n = 0;
    while (ack_o !== 1'b1 && n < 4) begin @(negedge clk); n++; end
    commit = cyc;
    n_checks++;
    if (ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ack adr=%h: ack_o=%b, required 1", adr, ack_o);
    end
    stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    n = 0;
    while (ack_o !== 1'b0 && n < 4) begin @(negedge clk); n++; end
    n_checks++;
    if (ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ack_fall adr=%h: ack_o=%b, required 0", adr, ack_o);
    end
  endtask

  task automatic bus_read(input logic [31:0] adr, input logic [31:0] expected, input string name);
    int n;
    logic [31:0] want;
    sb_q.push_back(expected);
    stb_i = 1'b1; we_i = 1'b0; adr_i = adr; sel_i = 4'hF;
    @(negedge clk);
    n = 0;
    while (ack_o !== 1'b1 && n < 4) begin @(negedge clk); n++; end
    want = sb_q.pop_front();
    n_checks++;
    if (ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: no ack_o, required ack with data %h", name, want);
    end else if (dat_o !== want) begin
      n_fail++;
      $display("FAIL %s: dat_o=%h, required %h", name, dat_o, want);
    end
    stb_i = 1'b0;
    @(negedge clk);
    n = 0;
    while (ack_o !== 1'b0 && n < 4) begin @(negedge clk); n++; end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_irq_rise(input int max_cycles, output int at);
    int n = 0;
    while (irq_o !== 1'b1 && n < max_cycles) begin @(negedge clk); n++; end
    at = (irq_o === 1'b1) ? cyc : -1;
  endtask

  task automatic test_reset();
    int hold_ok;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    n_checks++;
    if (ack_o !== 1'b0 || irq_o !== 1'b0 || dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b irq=%b dat=%h, required 0 0 00000000", ack_o, irq_o, dat_o);
    end
    // Strobe held three cycles: ack must lag by one edge and follow the strobe exactly.
    stb_i = 1'b1; we_i = 1'b0; adr_i = A_COUNT; sel_i = 4'hF;
    n_checks++;
    if (ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_before_edge: ack_o=%b, required 0", ack_o);
    end
    hold_ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (ack_o !== 1'b1) hold_ok = 0;
    end
    n_checks++;
    if (hold_ok != 1) begin
      n_fail++;
      $display("FAIL ack_hold: ack_o dropped while stb_i held, required 1 for 3 cycles");
    end
    stb_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_release: ack_o=%b, required 0", ack_o);
    end
    bus_read(A_CTRL,   32'h0, "reset_ctrl");
    bus_read(A_LOAD,   32'h0, "reset_load");
    bus_read(A_COUNT,  32'h0, "reset_count");
    bus_read(A_STATUS, 32'h0, "reset_status");
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: irq_o=%b, required 0", irq_o);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    bus_write(A_LOAD, 32'h1122_3344, 4'hF, c);
    bus_write(A_LOAD, 32'hAABB_CCDD, 4'b0101, c);
    bus_read(A_LOAD, 32'h11BB_33DD, "load_lanes");
    bus_read(32'hFFFF_FFF4, 32'h11BB_33DD, "load_alias_high_addr");
    bus_write(32'h1234_5007, 32'h0000_00EE, 4'b0001, c);
    bus_read(A_LOAD, 32'h11BB_33EE, "load_alias_write");
  endtask

  task automatic test_ctrl_lanes();
    int c;
    bus_write(A_CTRL, 32'hFFFF_FFFF, 4'b0001, c);
    bus_read(A_CTRL, 32'h0000_0007, "ctrl_low_lane");
    bus_write(A_CTRL, 32'h0005_0000, 4'b1100, c);
    bus_read(A_CTRL, 32'h0005_0007, "ctrl_pre_lanes");
    bus_write(A_CTRL, 32'h0, 4'hF, c);
    bus_write(A_STATUS, 32'h1, 4'b0001, c);
    bus_read(A_STATUS, 32'h0, "status_cleared");
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_cleanup_irq: irq_o=%b, required 0", irq_o);
    end
  endtask

  task automatic test_oneshot();
    int w, c, at;
    bus_write(A_COUNT, 32'd3, 4'hF, c);
    bus_write(A_CTRL, 32'h0000_0005, 4'hF, w);
    wait_irq_rise(20, at);
    // Ticks each cycle: COUNT 2,1,0, EXP on edge w+4, irq one edge later.
    n_checks++;
    if (at != w + 5) begin
      n_fail++;
      $display("FAIL oneshot_irq_time: irq rose at edge +%0d, required +5", at - w);
    end
    bus_read(A_STATUS, 32'h1, "oneshot_exp");
    bus_read(A_CTRL,   32'h4, "oneshot_en_cleared");
    bus_read(A_COUNT,  32'h0, "oneshot_count_zero");
    bus_write(A_CTRL, 32'h0, 4'hF, c);
    bus_write(A_STATUS, 32'h1, 4'hF, c);
    bus_read(A_STATUS, 32'h0, "oneshot_cleanup");
  endtask

  task automatic test_auto_reload();
    int w, c, at;
    bus_write(A_LOAD, 32'd2, 4'hF, c);
    bus_write(A_COUNT, 32'd0, 4'hF, c);
    bus_write(A_CTRL, 32'h0001_0007, 4'hF, w);
    // Expiries land on edges w+2, w+8, w+14, ...
    wait_until(w + 2);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_irq_early: irq_o=%b at edge +2, required 0", irq_o);
    end
    bus_read(A_COUNT, 32'd2, "auto_reload_value");
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_irq_first: irq_o=%b at edge +4, required 1", irq_o);
    end
    wait_until(w + 5);
    bus_write(A_STATUS, 32'h1, 4'b0001, c);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL status_clear_irq: irq_o=%b one edge after clear, required 0", irq_o);
    end
    wait_irq_rise(20, at);
    n_checks++;
    if (at != w + 9) begin
      n_fail++;
      $display("FAIL auto_period: irq re-rose at edge +%0d, required +9", at - w);
    end
  endtask

  task automatic test_status_clear();
    int w, c;
    // Continues the auto-reload run; w is recovered from the known expiry schedule.
    w = cyc - 9;
    wait_until(w + 13);
    bus_write(A_STATUS, 32'h1, 4'b0001, c);
    n_checks++;
    if (c != w + 14) begin
      n_fail++;
      $display("FAIL collide_schedule: clear committed at edge +%0d, required +14", c - w);
    end
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_set_wins: irq_o=%b, required 1", irq_o);
    end
    @(negedge clk);
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_set_wins_late: irq_o=%b, required 1", irq_o);
    end
    bus_write(A_STATUS, 32'h0, 4'hF, c);
    bus_read(A_STATUS, 32'h1, "status_write_zero");
    bus_write(A_STATUS, 32'h1, 4'b1110, c);
    bus_read(A_STATUS, 32'h1, "status_lane_disabled");
  endtask

  task automatic test_reset_mid();
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_irq: irq_o=%b, required 1", irq_o);
    end
    stb_i = 1'b1; we_i = 1'b0; adr_i = A_COUNT; sel_i = 4'hF;
    @(negedge clk);
    n_checks++;
    if (ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_ack: ack_o=%b, required 1", ack_o);
    end
    rst_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ack_o !== 1'b0 || irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: ack=%b irq=%b, required 0 0", ack_o, irq_o);
    end
    rst_i = 1'b0;
    stb_i = 1'b0;
    @(negedge clk);
    bus_read(A_CTRL,   32'h0, "post_reset_ctrl");
    bus_read(A_COUNT,  32'h0, "post_reset_count");
    bus_read(A_STATUS, 32'h0, "post_reset_status");
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_irq: irq_o=%b, required 0", irq_o);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_ctrl_lanes();
    test_oneshot();
    test_auto_reload();
    test_status_clear();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
